// File: rtl/ysyx_22040931_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect-aware,
// single-entry output buffer toward decode.
module ysyx_22040931_fetch_ctrl #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_o,
  output logic [PC_W-1:0] inst_pc,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     inst_q, inst_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;
  logic            req_fire;

  assign req_fire = (state_q == S_REQ) && imem_req_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (req_fire) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          // a redirect in the response cycle makes the beat stale too
          if (drop_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            state_d   = S_OUT;
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
            pc_d      = pc_q + PC_W'(4);
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid || inst_ready) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid && (state_q != S_IDLE)) begin
      pc_d = redirect_pc;
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    busy           = 1'b0;
    case (state_q)
      S_REQ:   imem_req_valid = 1'b1;
      S_WAIT:  busy           = 1'b1;
      S_OUT:   inst_valid     = 1'b1;
      default: ;
    endcase
  end

  assign imem_req_addr = pc_q;
  assign inst_o        = inst_q;
  assign inst_pc       = inst_pc_q;

endmodule

// File: tb/tb_ysyx_22040931_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic checked
// against a transaction-level fetch model.
module tb_ysyx_22040931_fetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clock;
  logic        rst;
  logic        redir;
  logic [63:0] redir_pc;
  logic        req_v;
  logic        rq;
  logic [63:0] req_addr;
  logic        rsp_v;
  logic [31:0] rsp_d;
  logic        inst_v;
  logic        ir;
  logic [31:0] inst_d;
  logic [63:0] inst_a;
  logic        busy;

  int n_chk;
  int n_err;

  logic        m_idle;
  int          rst_cnt;
  logic [63:0] m_pc;
  logic        m_out;
  logic [63:0] m_out_addr;
  logic        m_drop;
  logic        m_pend;
  logic [31:0] m_pend_data;
  logic [63:0] m_pend_pc;
  int          lat;

  ysyx_22040931_fetch_ctrl dut (
    .clock          (clock),
    .reset          (rst),
    .redirect_valid (redir),
    .redirect_pc    (redir_pc),
    .imem_req_valid (req_v),
    .imem_req_ready (rq),
    .imem_req_addr  (req_addr),
    .imem_rsp_valid (rsp_v),
    .imem_rsp_data  (rsp_d),
    .inst_valid     (inst_v),
    .inst_ready     (ir),
    .inst_o         (inst_d),
    .inst_pc        (inst_a),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check the current cycle against the model, advance the model by the
  // events the next rising edge will commit, then move to the next negedge.
  task automatic tick();
    logic hs, take, rsp, p0, o0;
    if (rst) begin
      if (rst_cnt > 0) begin
        chk("rst_reqv", {63'd0, req_v}, 64'd0);
        chk("rst_instv", {63'd0, inst_v}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_addr", req_addr, RST_PC);
        chk("rst_inst", {32'd0, inst_d}, 64'd0);
        chk("rst_ipc", inst_a, 64'd0);
      end
      rst_cnt++;
      m_pc   = RST_PC;
      m_out  = 1'b0;
      m_drop = 1'b0;
      m_pend = 1'b0;
      m_idle = 1'b1;
    end else if (m_idle) begin
      rst_cnt = 0;
      chk("idle_reqv", {63'd0, req_v}, 64'd0);
      chk("idle_instv", {63'd0, inst_v}, 64'd0);
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_addr", req_addr, RST_PC);
      m_idle = 1'b0;
    end else begin
      chk("excl", {63'd0, req_v & inst_v}, 64'd0);
      chk("busy", {63'd0, busy}, {63'd0, m_out});
      chk("instv", {63'd0, inst_v}, {63'd0, m_pend});
      chk("reqv", {63'd0, req_v}, {63'd0, !m_out && !m_pend});
      chk("addr", req_addr, m_pc);
      if (m_pend) begin
        chk("inst", {32'd0, inst_d}, {32'd0, m_pend_data});
        chk("ipc", inst_a, m_pend_pc);
      end
      p0   = m_pend;
      o0   = m_out;
      hs   = !m_out && !m_pend && rq;
      take = p0 && ir;
      rsp  = o0 && rsp_v;
      if (rsp) begin
        m_out = 1'b0;
        if (!m_drop && !redir) begin
          m_pend      = 1'b1;
          m_pend_data = rsp_d;
          m_pend_pc   = m_out_addr;
          m_pc        = m_out_addr + 64'd4;
        end
      end
      if (p0 && (take || redir)) m_pend = 1'b0;
      if (hs) begin
        m_out      = 1'b1;
        m_out_addr = m_pc;
        m_drop     = redir;
        lat        = $urandom_range(0, 3);
      end else if (o0 && !rsp && redir) begin
        m_drop = 1'b1;
      end
      if (redir) m_pc = redir_pc;
    end
    @(negedge clock);
  endtask

  task automatic drive(input logic a_rq, input logic a_ir,
                       input logic a_rv, input logic [63:0] a_rpc,
                       input logic a_sv, input logic [31:0] a_sd);
    rq       = a_rq;
    ir       = a_ir;
    redir    = a_rv;
    redir_pc = a_rpc;
    rsp_v    = a_sv;
    rsp_d    = a_sd;
  endtask

  initial begin
    logic [63:0] rp;
    n_chk   = 0;
    n_err   = 0;
    rst_cnt = 0;
    m_idle  = 1'b1;
    m_pc    = RST_PC;
    m_out   = 1'b0;
    m_drop  = 1'b0;
    m_pend  = 1'b0;
    lat     = 0;
    rst     = 1'b1;
    drive(0, 0, 0, 64'd0, 0, 32'd0);
    @(negedge clock);
    tick();
    tick();

    // basic fetch, first request one cycle after release
    rst = 1'b0;
    drive(1, 1, 0, 64'd0, 0, 32'd0);
    tick();
    chk("t35_reqv", {63'd0, req_v}, 64'd1);
    chk("t35_addr0", req_addr, 64'h8000_0000);
    tick();
    tick();
    rsp_v = 1'b1;
    rsp_d = 32'h0000_0013;
    tick();
    rsp_v = 1'b0;
    chk("t35_instv", {63'd0, inst_v}, 64'd1);
    chk("t35_inst", {32'd0, inst_d}, 64'h13);
    chk("t35_ipc", inst_a, 64'h8000_0000);
    tick();
    chk("t35_addr1", req_addr, 64'h8000_0004);

    // decode stall for 5 cycles
    ir = 1'b0;
    tick();
    rsp_v = 1'b1;
    rsp_d = 32'h0010_0093;
    tick();
    rsp_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t36_instv", {63'd0, inst_v}, 64'd1);
      chk("t36_ipc", inst_a, 64'h8000_0004);
      chk("t36_noreq", {63'd0, req_v}, 64'd0);
      tick();
    end
    ir = 1'b1;
    tick();
    chk("t36_reqv", {63'd0, req_v}, 64'd1);
    chk("t36_addr", req_addr, 64'h8000_0008);

    // redirect while waiting
    tick();
    redir    = 1'b1;
    redir_pc = 64'h8000_1000;
    tick();
    redir = 1'b0;
    rsp_v = 1'b1;
    rsp_d = 32'hDEAD_BEEF;
    tick();
    rsp_v = 1'b0;
    chk("t37_instv", {63'd0, inst_v}, 64'd0);
    chk("t37_reqv", {63'd0, req_v}, 64'd1);
    chk("t37_addr", req_addr, 64'h8000_1000);

    // redirect coincident with request handshake
    redir    = 1'b1;
    redir_pc = 64'h8000_2000;
    tick();
    redir = 1'b0;
    chk("t38_busy", {63'd0, busy}, 64'd1);
    chk("t38_pc", req_addr, 64'h8000_2000);
    rsp_v = 1'b1;
    rsp_d = 32'h1234_5678;
    tick();
    rsp_v = 1'b0;
    chk("t38_instv", {63'd0, inst_v}, 64'd0);
    chk("t38_reqv", {63'd0, req_v}, 64'd1);
    chk("t38_addr", req_addr, 64'h8000_2000);

    // pc wrap
    rq       = 1'b0;
    redir    = 1'b1;
    redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redir = 1'b0;
    rq    = 1'b1;
    chk("t39_addr", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    rsp_v = 1'b1;
    rsp_d = 32'h0000_0013;
    tick();
    rsp_v = 1'b0;
    chk("t39_ipc", inst_a, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("t39_wrap", req_addr, 64'd0);
    chk("t39_reqv", {63'd0, req_v}, 64'd1);

    // reset during WAIT, stray response afterwards, redirect in IDLE
    tick();
    rst = 1'b1;
    tick();
    rsp_v = 1'b1;
    rsp_d = 32'hBAD0_BAD0;
    tick();
    rst      = 1'b0;
    redir    = 1'b1;
    redir_pc = 64'h0000_1234;
    tick();
    redir = 1'b0;
    rq    = 1'b0;
    chk("t40_reqv", {63'd0, req_v}, 64'd1);
    chk("t40_addr", req_addr, 64'h8000_0000);
    chk("t40_instv", {63'd0, inst_v}, 64'd0);
    tick();
    rsp_v = 1'b0;
    chk("t40_instv2", {63'd0, inst_v}, 64'd0);
    chk("t40_busy", {63'd0, busy}, 64'd0);
    chk("t40_addr2", req_addr, 64'h8000_0000);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      rq  = ($urandom_range(0, 9) < 7);
      ir  = ($urandom_range(0, 9) < 6);
      rp  = {$urandom(), $urandom()};
      rp[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) rp = 64'hFFFF_FFFF_FFFF_FFFC;
      redir    = ($urandom_range(0, 11) == 0);
      redir_pc = rp;
      rsp_d    = $urandom();
      rsp_v    = 1'b0;
      if (m_out && !m_idle) begin
        if (lat == 0) rsp_v = 1'b1;
        else lat--;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_22040931_fetch_ctrl.md
YSYX_22040931_FETCH_CTRL -- requirements
Module: ysyx_22040931_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-002 Parameter PC_W, default 64, PC width.
REQ-003 clock  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 redirect_valid  input  1  branch/jump/trap redirect request from execute.
REQ-006 redirect_pc  input  PC_W  redirect target address.
REQ-007 imem_req_valid  output  1  instruction memory request valid.
REQ-008 imem_req_ready  input  1  instruction memory accepts the request.
REQ-009 imem_req_addr  output  PC_W  instruction memory request address.
REQ-010 imem_rsp_valid  input  1  instruction memory response valid, one beat per accepted request.
REQ-011 imem_rsp_data  input  32  fetched instruction word.
REQ-012 inst_valid  output  1  instruction valid to decode.
REQ-013 inst_ready  input  1  decode accepts the instruction.
REQ-014 inst_o  output  32  instruction to decode.
REQ-015 inst_pc  output  PC_W  address of inst_o.
REQ-016 busy  output  1  high while a request is outstanding, that is, in WAIT.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, OUT; one request outstanding at most.
REQ-018 IDLE: all valid outputs low; unconditional transition to REQ on the next edge, so the first request appears 1 cycle after reset deasserts.
REQ-019 REQ: imem_req_valid=1 and imem_req_addr=pc; on imem_req_valid&&imem_req_ready, go to WAIT.
REQ-020 WAIT: on imem_rsp_valid with no drop flag set, latch inst_o<=imem_rsp_data and inst_pc<=pc, set pc<=pc+4, go to OUT.
REQ-021 OUT: inst_valid=1 with inst_o and inst_pc held stable; on inst_ready, go to REQ, so the next request is issued the cycle after acceptance.
REQ-022 pc+4 wraps modulo 2^PC_W; no exception is raised on wrap.
REQ-023 Redirect has priority over every other pc update: any cycle with redirect_valid=1 and state not IDLE sets pc<=redirect_pc.
REQ-024 Redirect in REQ without handshake: stay in REQ; imem_req_addr shows redirect_pc from the next cycle; the memory tolerates an address change while unaccepted.
REQ-025 Redirect in REQ with handshake in the same cycle: go to WAIT with drop=1.
REQ-026 Redirect in WAIT: set drop=1; a response arriving in the same cycle is discarded and the block goes to REQ.
REQ-027 WAIT with drop=1 on imem_rsp_valid: discard data, clear drop, go to REQ; inst_valid stays 0.
REQ-028 Redirect in OUT: the instruction is withdrawn (inst_valid=0 next cycle) and the block goes to REQ; if inst_ready is also high, the handshake completes and counts as consumed.
REQ-029 Redirect in IDLE is ignored.
REQ-030 inst_valid is never asserted for a discarded response.
REQ-031 imem_req_valid and inst_valid are never high in the same cycle.

Reset
REQ-032 On reset: state=IDLE, pc=RESET_PC, drop=0, inst_o=0, inst_pc=0, imem_req_valid=0, inst_valid=0, busy=0.
REQ-033 Reset asserted mid-transaction aborts it immediately; any later imem_rsp_valid for the aborted request is ignored because the state is IDLE or REQ.
REQ-034 imem_req_addr equals pc in every state, so it reads RESET_PC during reset.

Verification
REQ-035 Release reset, req_ready=1, response after 2 cycles with 0x00000013, inst_ready=1 -> first req at 0x80000000 one cycle after release; inst_o=0x13, inst_pc=0x80000000; second req at 0x80000004.
REQ-036 Hold inst_ready=0 for 5 cycles in OUT -> inst_valid, inst_o, inst_pc stable, no new imem request; acceptance causes req at pc+4 the following cycle.
REQ-037 Redirect to 0x80001000 in WAIT, then response 0xDEADBEEF -> response discarded, inst_valid stays 0, next req at 0x80001000.
REQ-038 Redirect to 0x80002000 in the same cycle as a REQ handshake -> drop set; the response is discarded; next req at 0x80002000.
REQ-039 redirect_pc=64'hFFFF_FFFF_FFFF_FFFC, fetch completes -> next req at 0x0.
REQ-040 Assert reset while in WAIT, then imem_rsp_valid fires -> no inst_valid; after release, req at 0x80000000.
